postadd_sched: RTL and testbench
================================

// Module: postadd_sched
// PURPOSE
//  Beat sequencer for the postadder -> L3touint reduction path. Accepts operand beats over valid/ready.
//  Each beat carries an op, an accumulator slot and a last flag. Drives postadder mode3/addr3/outsel.
//  Enforces the per-slot carry-headroom budget and tags each L3touint result with its slot.
//  It is the only writer of postadder control.
// PARAMETERS
//  N_SLOT    4    accumulator slots in postadder reg3; addr3 width SLOT_W = $clog2(N_SLOT) = 2
//  ACC_MAX   128  max accumulating beats per job = 2**(L3_CARRY-1)
//  PIPE_LAT  6    cycles from postadder input register to valid L3touint dout
// PORTS
//  clk        in   1       single clock, all logic posedge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       beat offered
//  in_ready   out  1       beat accepted when in_valid & in_ready (fire)
//  in_op      in   3       pa_op_t: 001 LOAD, 010 ADD, 011 SUB(din-acc), 100 RSUB(acc-din), 101 NEG(Mod-acc)
//  in_slot    in   SLOT_W  target accumulator slot
//  in_last    in   1       final beat of the job for in_slot
//  flush      in   1       level; request drain of all in-flight results
//  issue_en   out  1       registered fire; data owner latches operand into in_L1 on this
//  mode3      out  3       postadder mode3; 000 (hold) when no beat issued
//  addr3      out  SLOT_W  postadder addr3
//  outsel     out  2       constant 2'b10 (reg3 path)
//  res_valid  out  1       L3touint dout is a completed job result this cycle
//  res_slot   out  SLOT_W  slot of that result
//  flush_done out  1       one-cycle pulse; pipeline empty after flush
//  err_ovf    out  1       sticky; beat accepted to a slot whose count == ACC_MAX
//  err_op     out  1       sticky; beat with op 000/110/111 accepted
// BEHAVIOUR
//  Reset values:
//   - in_ready=0; issue_en=0; mode3=000; addr3=0; outsel=10; res_valid=0; res_slot=0; flush_done=0
//   - err_*=0; all slot counters=0; state=IDLE
//  FSM states:
//   - IDLE: in_ready=1. Enters RUN on fire.
//   - RUN: in_ready=1. Enters DRAIN on flush. Returns to IDLE when no beat fires and in-flight=0.
//   - DRAIN: in_ready=0 until the in-flight shift register is all-zero. Then pulses flush_done and goes to IDLE.
//     In DRAIN, flush_done follows the all-zero condition even when flush is already low.
//  Flush while in IDLE with in-flight=0: flush_done pulses the next cycle.
//  Issue: on fire, next cycle issue_en=1, mode3=in_op, addr3=in_slot. Otherwise mode3=000, issue_en=0.
//  Illegal op (000/110/111): beat is consumed. Sets err_op and issues mode3=000. Slot counter unchanged.
//   - If in_last=1, res_valid is still produced and the slot counter is still cleared.
//  Slot counter cnt[s], 8 bits:
//   - LOAD sets cnt=1.
//   - ADD/SUB/RSUB do cnt+1 and saturate at ACC_MAX.
//   - NEG leaves cnt unchanged.
//   - A LOAD that is also in_last clears cnt to 0 after the issue.
//  Overflow: an ADD/SUB/RSUB fired with cnt==ACC_MAX sets err_ovf. The beat is still issued; its result is undefined.
//  ADD/SUB/RSUB/NEG to a slot with cnt==0 (no LOAD yet) accumulates onto reg3 contents.
//   - Legal; the block does not check it; cnt becomes 1.
//  Job end: fire with in_last pushes {1,slot} into a PIPE_LAT-deep shift register in parallel with issue.
//   - res_valid/res_slot appear exactly 1+PIPE_LAT cycles after the fire cycle.
//   - cnt[slot] clears to 0 in the cycle after the fire.
//  Back-to-back beats to the same slot are legal every cycle; there is no read-after-write stall.
//  Simultaneous last-beat on slot A and first LOAD on A in the next cycle: legal; new job starts clean.
//  flush asserted in the same cycle as a fire: the beat is accepted, then DRAIN.
//  err_* clear only on rst.
//  rst mid-operation: all in-flight tags are dropped and no res_valid is produced for them.
//   - Postadder contents are not owned here; the bench zeroes reg3 separately.
// STRUCTURE
//  PARAMS_BN254_d0 additions:
//   - typedef enum logic [2:0] pa_op_t
//   - localparam PA_ACC_MAX = 2**(L3_CARRY-1)
//   - localparam PA_PIPE_LAT = 6
//  Sub-module: pa_tag_pipe, a parameterised valid+slot shift register with an any-busy OR output.
//  The FSM and slot counters live in the top.
// TESTING
//  1. Single job to slot 2: LOAD then ADD x4, last on 5th beat at cycle t.
//     Expect res_valid=1, res_slot=2 at t+7 only; L3touint dout == a+b+c+d+e mod p.
//  2. 128 beats to slot 0 (LOAD + 127 ADD, last set) -> err_ovf stays 0.
//     Rerun with 129 beats -> err_ovf=1 from the 129th fire's next cycle.
//  3. Interleaved slots 0/1/3 every cycle, each 3 beats, lasts at cycles 10, 11, 12.
//     Expect res_valid at 17, 18, 19 with res_slot 0, 1, 3.
//  4. Flush asserted one cycle after a last beat fired at cycle 20: in_ready=0 from cycle 22.
//     Expect res_valid at 27, flush_done at 28, in_ready=1 at 29.
//  5. Modes 3..5 sweep (SUB, RSUB, NEG) against the golden acc model, 100000 random beats.
//     Slot restarted with LOAD every 128 beats -> zero mismatches, err_* = 0.
//  6. rst pulsed for 2 cycles while 3 tags are in flight -> no res_valid for the 8 cycles after release.
//     Also in_ready=0 during rst; op 3'b111 beat afterwards -> err_op=1, mode3=000.

Source files
------------

// File: rtl/postadd_sched_pkg.sv
// postadd_sched_pkg: shared types and constants for the postadder beat sequencer.
package postadd_sched_pkg;
    localparam int N_SLOT      = 4;
    localparam int SLOT_W      = $clog2(N_SLOT);
    localparam int L3_CARRY    = 8;
    localparam int PA_ACC_MAX  = 2 ** (L3_CARRY - 1);
    localparam int PA_PIPE_LAT = 6;
    localparam int CNT_W       = 8;
    typedef enum logic [2:0] {
        PA_HOLD = 3'b000,
        PA_LOAD = 3'b001,
        PA_ADD  = 3'b010,
        PA_SUB  = 3'b011,
        PA_RSUB = 3'b100,
        PA_NEG  = 3'b101
    } pa_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/postadd_sched_if.sv
// postadd_sched_if: beat input, postadder control and result-tag signals.
interface postadd_sched_if;
    import postadd_sched_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [SLOT_W-1:0] in_slot;
    logic              in_last;
    logic              flush;
    logic              issue_en;
    logic [2:0]        mode3;
    logic [SLOT_W-1:0] addr3;
    logic [1:0]        outsel;
    logic              res_valid;
    logic [SLOT_W-1:0] res_slot;
    logic              flush_done;
    logic              err_ovf;
    logic              err_op;
    modport master (
        output in_valid, in_op, in_slot, in_last, flush,
        input  in_ready, issue_en, mode3, addr3, outsel, res_valid, res_slot, flush_done, err_ovf, err_op
    );
    modport slave (
        input  in_valid, in_op, in_slot, in_last, flush,
        output in_ready, issue_en, mode3, addr3, outsel, res_valid, res_slot, flush_done, err_ovf, err_op
    );
endinterface

// File: rtl/postadd_sched_tag_pipe.sv
// pa_tag_pipe: valid+slot shift register tracking job results through the postadder pipeline.
module pa_tag_pipe
    import postadd_sched_pkg::*;
#(
    parameter int DEPTH = PA_PIPE_LAT + 1,
    parameter int W     = SLOT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] slot_i,
    output logic         valid_o,
    output logic [W-1:0] slot_o,
    output logic         busy_o
);
    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     slot_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            vld_q     <= {vld_q[DEPTH-2:0], push_i};
            slot_q[0] <= slot_i;
            for (int i = 1; i < DEPTH; i++) slot_q[i] <= slot_q[i-1];
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign slot_o  = slot_q[DEPTH-1];
    assign busy_o  = |vld_q;
endmodule

// File: rtl/postadd_sched.sv
// postadd_sched: sequences operand beats into postadder control, tracks per-slot carry headroom
// and tags completed job results with their slot.
module postadd_sched
    import postadd_sched_pkg::*;
(
    input logic            clk,
    input logic            rst,
    postadd_sched_if.slave bus
);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [N_SLOT];
    logic [CNT_W-1:0]  cnt_d, cur;
    logic              issue_q, ovf_q, op_err_q;
    logic [2:0]        mode_q;
    logic [SLOT_W-1:0] addr_q;
    logic              fire, busy, legal, acc, sat;

    assign bus.in_ready = state_q != DRAIN && !rst;
    assign fire  = bus.in_valid && bus.in_ready;
    assign legal = bus.in_op inside {PA_LOAD, PA_ADD, PA_SUB, PA_RSUB, PA_NEG};
    assign acc   = bus.in_op inside {PA_ADD, PA_SUB, PA_RSUB};
    assign cur   = cnt_q[bus.in_slot];
    assign sat   = cur == CNT_W'(PA_ACC_MAX);

    always_comb begin
        state_d        = state_q;
        bus.flush_done = 1'b0;
        if (state_q == DRAIN) begin
            bus.flush_done = !busy;
            state_d        = busy ? DRAIN : IDLE;
        end else if (bus.flush) state_d = DRAIN;
        else if (fire) state_d = RUN;
        else if (state_q == RUN && !busy) state_d = IDLE;
    end

    // A last beat always leaves the slot clean for the next job, whatever its op.
    always_comb begin
        cnt_d = cur;
        if (bus.in_op == PA_LOAD) cnt_d = CNT_W'(1);
        else if (acc) cnt_d = sat ? cur : cur + 1'b1;
        else if (bus.in_op == PA_NEG && cur == '0) cnt_d = CNT_W'(1);
        if (bus.in_last) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            issue_q  <= 1'b0;
            mode_q   <= PA_HOLD;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            op_err_q <= 1'b0;
            for (int i = 0; i < N_SLOT; i++) cnt_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            issue_q  <= fire;
            mode_q   <= (fire && legal) ? bus.in_op : PA_HOLD;
            ovf_q    <= ovf_q | (fire && acc && sat);
            op_err_q <= op_err_q | (fire && !legal);
            if (fire) begin
                addr_q              <= bus.in_slot;
                cnt_q[bus.in_slot]  <= cnt_d;
            end
        end
    end

    pa_tag_pipe #(.DEPTH(PA_PIPE_LAT + 1), .W(SLOT_W)) u_tags (
        .clk    (clk),
        .rst    (rst),
        .push_i (fire && bus.in_last),
        .slot_i (bus.in_slot),
        .valid_o(bus.res_valid),
        .slot_o (bus.res_slot),
        .busy_o (busy)
    );

    assign bus.issue_en = issue_q;
    assign bus.mode3    = mode_q;
    assign bus.addr3    = addr_q;
    assign bus.outsel   = 2'b10;
    assign bus.err_ovf  = ovf_q;
    assign bus.err_op   = op_err_q;
endmodule

// File: tb/tb_postadd_sched.sv
// tb_postadd_sched: directed + short random stimulus against a job/result model of the sequencer.
module tb_postadd_sched;
    import postadd_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    postadd_sched_if bus();
    postadd_sched dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: per-slot beat counts, sticky errors, pending results as (due cycle, slot) queues.
    int cnt [N_SLOT];
    bit m_ovf, m_operr, draining, e_issue, m_fire, m_rdy, exp_rv;
    int e_mode, e_addr, m_op, m_s;
    int due_q[$];
    int slot_q[$];

    always @(posedge clk) begin
        if (!rst) begin
            m_rdy  = !draining;
            m_fire = bus.in_valid && m_rdy;
            e_issue = m_fire;
            e_mode  = 0;
            if (m_fire) begin
                m_op   = int'(bus.in_op);
                m_s    = int'(bus.in_slot);
                e_addr = m_s;
                if (m_op < 1 || m_op > 5) m_operr = 1;
                else begin
                    e_mode = m_op;
                    if (m_op == 1) cnt[m_s] = 1;
                    else if (m_op == 5) begin
                        if (cnt[m_s] == 0) cnt[m_s] = 1;
                    end else if (cnt[m_s] == PA_ACC_MAX) m_ovf = 1;
                    else cnt[m_s]++;
                end
                if (bus.in_last) begin
                    cnt[m_s] = 0;
                    due_q.push_back(cyc + 1 + PA_PIPE_LAT);
                    slot_q.push_back(m_s);
                end
            end
            if (draining && due_q.size() == 0) draining = 0;
            else if (!draining && bus.flush) draining = 1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SLOT; i++) cnt[i] = 0;
            m_ovf = 0; m_operr = 0; draining = 0;
            e_issue = 0; e_mode = 0; e_addr = 0;
            due_q.delete(); slot_q.delete();
        end
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(slot_q.pop_front());
        end
        exp_rv = due_q.size() > 0 && due_q[0] == cyc;
        chk("in_ready", bus.in_ready, !rst && !draining);
        chk("issue_en", bus.issue_en, e_issue);
        chk("mode3", bus.mode3, e_mode);
        chk("addr3", bus.addr3, e_addr);
        chk("outsel", bus.outsel, 2);
        chk("res_valid", bus.res_valid, exp_rv);
        if (exp_rv) chk("res_slot", bus.res_slot, slot_q[0]);
        chk("flush_done", bus.flush_done, !rst && draining && due_q.size() == 0);
        chk("err_ovf", bus.err_ovf, m_ovf);
        chk("err_op", bus.err_op, m_operr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] op, input int s, input bit last);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_slot  = SLOT_W'(s);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = 3'b000;
        bus.in_slot  = '0;
        bus.in_last  = 1'b0;
        bus.flush    = 1'b0;
        tick();
        @(negedge clk);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst res_slot", bus.res_slot, 0);
        chk("rst mode3", bus.mode3, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single job to slot 2, result exactly 7 cycles after the last fire.
        beat(PA_LOAD, 2, 0);
        repeat (3) beat(PA_ADD, 2, 0);
        beat(PA_ADD, 2, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("t1 early res_valid", bus.res_valid, 0);
        tick();
        @(negedge clk);
        chk("t1 res_valid", bus.res_valid, 1);
        chk("t1 res_slot", bus.res_slot, 2);
        tick();
        @(negedge clk);
        chk("t1 late res_valid", bus.res_valid, 0);
        repeat (3) tick();

        // Random SUB/RSUB/NEG/ADD mix with periodic LOAD restarts.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            else begin
                int s = $urandom_range(0, N_SLOT - 1);
                logic [2:0] op;
                op = (i % 16 == 0) ? PA_LOAD : 3'($urandom_range(1, 5));
                beat(op, s, $urandom_range(0, 7) == 0);
            end
        end
        repeat (10) tick();
        @(negedge clk);
        chk("t5 err_ovf", bus.err_ovf, 0);
        chk("t5 err_op", bus.err_op, 0);
        tick();

        // Interleaved slots 0/1/3, lasts on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            beat(k == 0 ? PA_LOAD : PA_ADD, 0, k == 2);
            beat(k == 0 ? PA_LOAD : PA_SUB, 1, k == 2);
            beat(k == 0 ? PA_LOAD : PA_RSUB, 3, k == 2);
        end
        repeat (4) tick();
        @(negedge clk);
        chk("t3 slot0", bus.res_slot, 0);
        tick();
        @(negedge clk);
        chk("t3 slot1", bus.res_slot, 1);
        tick();
        @(negedge clk);
        chk("t3 slot3", bus.res_slot, 3);
        chk("t3 valid", bus.res_valid, 1);
        repeat (3) tick();

        // Flush one cycle after a last beat.
        beat(PA_LOAD, 1, 0);
        beat(PA_ADD, 1, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("t4 ready low", bus.in_ready, 0);
        repeat (5) tick();
        @(negedge clk);
        chk("t4 res_valid", bus.res_valid, 1);
        tick();
        @(negedge clk);
        chk("t4 flush_done", bus.flush_done, 1);
        chk("t4 still draining", bus.in_ready, 0);
        tick();
        @(negedge clk);
        chk("t4 ready back", bus.in_ready, 1);
        chk("t4 done once", bus.flush_done, 0);
        tick();

        // Flush with an empty pipeline: done on the very next cycle.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("idle flush_done", bus.flush_done, 1);
        tick();

        // Headroom: 128 beats is within budget, the 129th overflows.
        beat(PA_LOAD, 0, 0);
        repeat (126) beat(PA_ADD, 0, 0);
        beat(PA_ADD, 0, 1);
        @(negedge clk);
        chk("t2 128 no ovf", bus.err_ovf, 0);
        tick();
        beat(PA_LOAD, 0, 0);
        repeat (127) beat(PA_ADD, 0, 0);
        @(negedge clk);
        chk("t2 pre-129 ovf", bus.err_ovf, 0);
        tick();
        beat(PA_ADD, 0, 1);
        @(negedge clk);
        chk("t2 129 ovf", bus.err_ovf, 1);
        repeat (3) tick();

        // Reset with three tags in flight drops them.
        beat(PA_LOAD, 0, 1);
        beat(PA_LOAD, 1, 1);
        beat(PA_LOAD, 2, 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("t6 ready in rst", bus.in_ready, 0);
        chk("t6 ovf cleared", bus.err_ovf, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6 no res_valid", bus.res_valid, 0);
            tick();
        end
        beat(3'b111, 1, 0);
        @(negedge clk);
        chk("t6 err_op", bus.err_op, 1);
        chk("t6 mode3 hold", bus.mode3, 0);
        chk("t6 issue_en", bus.issue_en, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
